// File: rtl/kicp_mem_pkg.sv
// Shared definitions for the accelerator SRAM arbiter.
//   - Memory op encodings carried on each requester's 2-bit op field.
//   - Requester slot indices (slot index doubles as fixed priority rank).
//   - Arbiter FSM state encoding.
//   - Helpers: op validity test and round-robin pointer advance.
package kicp_mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  localparam int REQ_WB    = 0;
  localparam int REQ_MMUL  = 1;
  localparam int REQ_MCONV = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

  // 2'b10 is reserved and behaves like "no request".
  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

  // Slot after the winner, modulo 3, so the winner becomes lowest priority.
  function automatic logic [1:0] ptr_after(input logic [2:0] win_oh);
    logic [1:0] nxt;
    nxt = 2'd0;
    if (win_oh[0]) nxt = 2'd1;
    else if (win_oh[1]) nxt = 2'd2;
    return nxt;
  endfunction

endpackage

// File: rtl/kicp_req_picker.sv
// Combinational 3-way request picker.
// Ports:
//   valid     in  3  per-slot request valid
//   start     in  2  slot searched first (0..2); 3 is treated as 0
//   win_oh    out 3  one-hot winner, 0 when nothing is valid
//   any_valid out 1  at least one slot is requesting
// The search order is start, start+1, start+2 (mod 3); start=0 gives
// fixed priority slot0 > slot1 > slot2.
module kicp_req_picker (
  input  logic [2:0] valid,
  input  logic [1:0] start,
  output logic [2:0] win_oh,
  output logic       any_valid
);

  function automatic logic [2:0] first_of(input logic [2:0] v,
                                          input logic [1:0] a,
                                          input logic [1:0] b,
                                          input logic [1:0] c);
    logic [2:0] oh;
    oh = 3'b000;
    if (v[a])      oh[a] = 1'b1;
    else if (v[b]) oh[b] = 1'b1;
    else if (v[c]) oh[c] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    win_oh = 3'b000;
    case (start)
      2'd1:    win_oh = first_of(valid, 2'd1, 2'd2, 2'd0);
      2'd2:    win_oh = first_of(valid, 2'd2, 2'd0, 2'd1);
      default: win_oh = first_of(valid, 2'd0, 2'd1, 2'd2);
    endcase
  end

  assign any_valid = |valid;

endmodule

// File: rtl/kicp_sram_arbiter.sv
// Single-port accelerator SRAM (256 x 32) arbiter for three requesters:
// Wishbone DMA (slot 0), matmul core (slot 1), convolution core (slot 2).
// Each access walks IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE, so one op
// completes every 4 cycles at best and req_done rises 3 cycles after the
// request is sampled in IDLE.
// Build option:
//   KICP_ARB_RR_EN  defined   -> round-robin arbitration
//                   undefined -> fixed priority slot0 > slot1 > slot2
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_op/addr/wdata      packed per-requester op (2b), word address, write data
//   req_done               one-cycle one-hot completion pulse to the served slot
//   rd_data                last read word, held until the next read completes
//   grant                  one-hot owner of the in-flight access, 0 when idle
//   busy                   high outside IDLE
//   sram_en/we/addr/wdata  SRAM EN0/WE0/A0/Di0
//   sram_rdata             SRAM Do0
module kicp_sram_arbiter
  import kicp_mem_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int NREQ   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [AWIDTH*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0]     req_wdata,
  output logic [NREQ-1:0]        req_done,
  output logic [31:0]            rd_data,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   sram_en,
  output logic [3:0]             sram_we,
  output logic [AWIDTH-1:0]      sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata
);

  arb_state_e state, state_next;

  logic [NREQ-1:0]   req_vld;
  logic [NREQ-1:0]   pick_oh;
  logic              pick_any;
  logic [1:0]        start_ptr;

  logic [1:0]        sel_op;
  logic [AWIDTH-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Latched request, stable for the whole access regardless of inputs.
  logic [NREQ-1:0]   win_oh_p0;
  logic [1:0]        op_p0;
  logic [AWIDTH-1:0] addr_p0;
  logic [31:0]       wdata_p0;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_vld[i] = op_is_valid(req_op[2*i +: 2]);
    end
  end

  kicp_req_picker u_picker (
    .valid     (req_vld),
    .start     (start_ptr),
    .win_oh    (pick_oh),
    .any_valid (pick_any)
  );

`ifdef KICP_ARB_RR_EN
  logic [1:0] rr_ptr;

  // Advance past the winner as the access is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (state == ST_IDLE && pick_any) begin
      rr_ptr <= ptr_after(pick_oh);
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = 2'd0;
`endif

  always_comb begin
    sel_op    = MEM_OP_NONE;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_op    = req_op[2*i +: 2];
        sel_addr  = req_addr[AWIDTH*i +: AWIDTH];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (pick_any) state_next = ST_ACCESS;
      ST_ACCESS:  state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Stage p0: request capture on the IDLE -> ACCESS edge
  always_ff @(posedge clk) begin
    if (reset) begin
      win_oh_p0 <= '0;
      op_p0     <= MEM_OP_NONE;
      addr_p0   <= '0;
      wdata_p0  <= '0;
    end else if (state == ST_IDLE && pick_any) begin
      win_oh_p0 <= pick_oh;
      op_p0     <= sel_op;
      addr_p0   <= sel_addr;
      wdata_p0  <= sel_wdata;
    end
  end

  // Stage p1: SRAM read data lands one cycle after the ACCESS edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (state == ST_CAPTURE && op_p0 == MEM_OP_READ) begin
      rd_data <= sram_rdata;
    end
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    grant      = (state != ST_IDLE) ? win_oh_p0 : '0;
    req_done   = (state == ST_DONE) ? win_oh_p0 : '0;
    sram_en    = (state == ST_ACCESS);
    sram_we    = (state == ST_ACCESS && op_p0 == MEM_OP_WRITE) ? 4'hF : 4'h0;
    sram_addr  = addr_p0;
    sram_wdata = wdata_p0;
  end

endmodule
